// File: rtl/hw_arith_pkg.sv
// Shared arithmetic definitions for the pipelined adder and the subtractor wrappers.
// s1_payload_t and out_payload_t describe the default 32/16 geometry. Blocks
// built with other widths declare matching local structs.
package hw_arith_pkg;

    localparam int ARITH_WIDTH = 32;
    localparam int ARITH_SPLIT = 16;

    typedef logic [ARITH_WIDTH-1:0] arith_word_t;

    typedef struct packed {
        logic [ARITH_SPLIT-1:0]             lo;
        logic                               c1;
        logic [ARITH_WIDTH-ARITH_SPLIT-1:0] a_hi;
        logic [ARITH_WIDTH-ARITH_SPLIT-1:0] b_hi;
        logic                               a_msb;
        logic                               b_msb;
    } s1_payload_t;

    typedef struct packed {
        arith_word_t sum;
        logic        cout;
        logic        ovf;
    } out_payload_t;

    // Two's-complement overflow: the operands share a sign and the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/hw_pipe_stage.sv
// Generic valid/ready register slice with a type-parameterised payload.
// The stage accepts a new beat when it is empty or its current beat leaves in
// the same cycle, so a chain of these sustains one beat per clock.
module hw_pipe_stage #(
    parameter type T = logic [31:0]
) (
    input  logic clk_main_a0,
    input  logic rst_main_n,
    input  logic i_valid,
    output logic o_ready,
    input  T     i_data,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);

    logic r_valid;
    T     r_data;
    logic w_advance;

    assign w_advance = !r_valid || i_ready;
    assign o_ready   = w_advance;
    assign o_valid   = r_valid;
    assign o_data    = r_data;

    // Payload and valid register; reset clears both so no stale beat survives.
    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_advance) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/hw_adder_pipe_32bit.sv
// Two-stage pipelined adder with valid/ready on both sides.
// Stage 1 adds the low SPLIT bits and registers the carry with the high
// operand halves; stage 2 finishes the high half and forms the flags.
// Optional macro HW_ADDER_SAT_EN: clamp the sum to the signed limits on overflow.
module hw_adder_pipe_32bit
    import hw_arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH,
    parameter int SPLIT = ARITH_SPLIT,
    parameter int CNT_W = 32
) (
    input  logic             clk_main_a0,
    input  logic             rst_main_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [CNT_W-1:0] op_count
);

    localparam int HI_W = WIDTH - SPLIT;

    typedef struct packed {
        logic [SPLIT-1:0] lo;
        logic             c1;
        logic [HI_W-1:0]  a_hi;
        logic [HI_W-1:0]  b_hi;
        logic             a_msb;
        logic             b_msb;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } out_t;

    s1_t              w_s1_d;
    s1_t              w_s1_q;
    out_t             w_out_d;
    out_t             w_out_q;
    logic             w_s1_ready;
    logic             w_s1_valid;
    logic             w_out_stage_ready;
    logic [SPLIT:0]   w_lo_full;
    logic [HI_W:0]    w_hi_full;
    logic [WIDTH-1:0] w_sum_raw;
    logic [CNT_W-1:0] r_op_count;

    // Low-half add and operand capture for stage 1.
    always_comb begin
        w_lo_full    = {1'b0, in_a[SPLIT-1:0]} + {1'b0, in_b[SPLIT-1:0]} + {{SPLIT{1'b0}}, in_cin};
        w_s1_d       = '0;
        w_s1_d.lo    = w_lo_full[SPLIT-1:0];
        w_s1_d.c1    = w_lo_full[SPLIT];
        w_s1_d.a_hi  = in_a[WIDTH-1:SPLIT];
        w_s1_d.b_hi  = in_b[WIDTH-1:SPLIT];
        w_s1_d.a_msb = in_a[WIDTH-1];
        w_s1_d.b_msb = in_b[WIDTH-1];
    end

    // High-half add, flags and optional clamp for the output register.
    always_comb begin
        w_hi_full    = {1'b0, w_s1_q.a_hi} + {1'b0, w_s1_q.b_hi} + {{HI_W{1'b0}}, w_s1_q.c1};
        w_sum_raw    = {w_hi_full[HI_W-1:0], w_s1_q.lo};
        w_out_d      = '0;
        w_out_d.sum  = w_sum_raw;
        w_out_d.cout = w_hi_full[HI_W];
        w_out_d.ovf  = signed_ovf(w_s1_q.a_msb, w_s1_q.b_msb, w_sum_raw[WIDTH-1]);
`ifdef HW_ADDER_SAT_EN
        if (w_out_d.ovf) begin
            w_out_d.sum = w_s1_q.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    hw_pipe_stage #(.T(s1_t)) u_s1 (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .i_valid     (in_valid),
        .o_ready     (w_s1_ready),
        .i_data      (w_s1_d),
        .o_valid     (w_s1_valid),
        .i_ready     (w_out_stage_ready),
        .o_data      (w_s1_q)
    );

    hw_pipe_stage #(.T(out_t)) u_out (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .i_valid     (w_s1_valid),
        .o_ready     (w_out_stage_ready),
        .i_data      (w_out_d),
        .o_valid     (out_valid),
        .i_ready     (out_ready),
        .o_data      (w_out_q)
    );

    // Reset is visible on in_ready so upstream never sees a phantom accept.
    assign in_ready = rst_main_n && w_s1_ready;
    assign out_sum  = w_out_q.sum;
    assign out_cout = w_out_q.cout;
    assign out_ovf  = w_out_q.ovf;
    assign op_count = r_op_count;

    // Count completed output handshakes; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n) begin
            r_op_count <= '0;
        end else if (out_valid && out_ready) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

endmodule
